// File: rtl/rsc_encoder.sv
// rtl/rsc_encoder.sv - 8-state RSC encoder (1+D2+D3 / 1+D+D3); define RSC_TAIL_EN for 3-cycle trellis termination
module rsc_encoder #(
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_en,
  output logic       sys_out,
  output logic       par_out,
  output logic       out_en,
  output logic       tail_flag,
  output logic       frame_done,
  output logic [6:0] frame_len,
  output logic       len_err
);

  typedef enum logic [1:0] {IDLE, ENC, TAIL, DONE} state_t;

  state_t     state, state_nx;
  logic       s1, s2, s3;
  logic       s1_nx, s2_nx, s3_nx;
  logic [6:0] count, count_nx;
  logic       sys_nx, par_nx, out_en_nx, done_nx, err_nx;
  logic [6:0] len_nx;
  logic       a_enc, par_enc, at_max, take;
`ifdef RSC_TAIL_EN
  logic [1:0] tail_cnt, tail_cnt_nx;
  logic       tail_nx;
`endif

  // Feedback node and parity for a data bit; the encoder only accepts bits from IDLE or a non-full ENC
  assign a_enc   = din ^ s2 ^ s3;
  assign par_enc = a_enc ^ s1 ^ s3;
  assign at_max  = (count == 7'(MAX_LEN));
  assign take    = din_en && ((state == IDLE) || ((state == ENC) && !at_max));

  // Next-state, trellis update and next registered outputs
  always_comb begin
    state_nx  = state;
    s1_nx     = s1;
    s2_nx     = s2;
    s3_nx     = s3;
    count_nx  = count;
    sys_nx    = 1'b0;
    par_nx    = 1'b0;
    out_en_nx = 1'b0;
    done_nx   = 1'b0;
    len_nx    = frame_len;
    err_nx    = len_err;
`ifdef RSC_TAIL_EN
    tail_cnt_nx = tail_cnt;
    tail_nx     = 1'b0;
`endif
    if (take) begin
      sys_nx    = din;
      par_nx    = par_enc;
      out_en_nx = 1'b1;
      s1_nx     = a_enc;
      s2_nx     = s1;
      s3_nx     = s2;
      count_nx  = count + 7'd1;
    end
    case (state)
      IDLE: begin
        if (din_en) state_nx = ENC;
      end
      ENC: begin
        if (din_en) begin
          // A full frame drops further bits and flags the overrun
          if (at_max) err_nx = 1'b1;
        end else begin
`ifdef RSC_TAIL_EN
          state_nx    = TAIL;
          tail_cnt_nx = 2'd0;
`else
          state_nx    = DONE;
`endif
        end
      end
      TAIL: begin
        if (din_en) err_nx = 1'b1;
`ifdef RSC_TAIL_EN
        // Termination input equals the feedback so the node value is zero and the register flushes
        sys_nx      = s2 ^ s3;
        par_nx      = s1 ^ s3;
        out_en_nx   = 1'b1;
        tail_nx     = 1'b1;
        s1_nx       = 1'b0;
        s2_nx       = s1;
        s3_nx       = s2;
        tail_cnt_nx = tail_cnt + 2'd1;
        if (tail_cnt == 2'd2) state_nx = DONE;
`else
        state_nx = IDLE;
`endif
      end
      DONE: begin
        if (din_en) err_nx = 1'b1;
        done_nx  = 1'b1;
        len_nx   = count;
        s1_nx    = 1'b0;
        s2_nx    = 1'b0;
        s3_nx    = 1'b0;
        count_nx = 7'd0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, trellis and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      count      <= 7'd0;
      sys_out    <= 1'b0;
      par_out    <= 1'b0;
      out_en     <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= 7'd0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      s1         <= s1_nx;
      s2         <= s2_nx;
      s3         <= s3_nx;
      count      <= count_nx;
      sys_out    <= sys_nx;
      par_out    <= par_nx;
      out_en     <= out_en_nx;
      frame_done <= done_nx;
      frame_len  <= len_nx;
      len_err    <= err_nx;
    end
  end

`ifdef RSC_TAIL_EN
  // Tail phase counter and tail marker register
  always_ff @(posedge clk) begin
    if (rst) begin
      tail_cnt  <= 2'd0;
      tail_flag <= 1'b0;
    end else begin
      tail_cnt  <= tail_cnt_nx;
      tail_flag <= tail_nx;
    end
  end
`else
  assign tail_flag = 1'b0;
`endif

endmodule

// File: tb/tb_rsc_encoder.sv
// tb/tb_rsc_encoder.sv - randomized self-checking bench for rsc_encoder against a polynomial reference model
module tb_rsc_encoder;

  localparam int MAX_LEN = 64;
`ifdef RSC_TAIL_EN
  localparam int TAIL_LEN = 3;
`else
  localparam int TAIL_LEN = 0;
`endif
  localparam int MIN_GAP = 2 + TAIL_LEN;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_en = 1'b0;
  logic       sys_out, par_out, out_en, tail_flag, frame_done, len_err;
  logic [6:0] frame_len;

  int n_checks = 0;
  int n_pass   = 0;

  bit         cap_sys[$];
  bit         cap_par[$];
  bit         cap_tail[$];
  logic [6:0] cap_len[$];
  int         viol = 0;

  always #5 clk = ~clk;

  rsc_encoder #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en),
    .sys_out(sys_out), .par_out(par_out), .out_en(out_en),
    .tail_flag(tail_flag), .frame_done(frame_done),
    .frame_len(frame_len), .len_err(len_err)
  );

  // Output monitor on the falling edge
  always @(negedge clk) begin
    if (out_en === 1'b1) begin
      cap_sys.push_back(sys_out);
      cap_par.push_back(par_out);
      cap_tail.push_back(tail_flag);
    end else if (sys_out === 1'b1 || par_out === 1'b1 || tail_flag === 1'b1) begin
      viol++;
    end
    if (TAIL_LEN == 0 && tail_flag === 1'b1) viol++;
    if (frame_done === 1'b1) cap_len.push_back(frame_len);
  end

  function automatic bit tap(input bit h[$], input int d);
    return (h.size() >= d) ? h[h.size() - d] : 1'b0;
  endfunction

  // Reference: feedback node a(k) = u(k) + a(k-2) + a(k-3), parity = a(k) + a(k-1) + a(k-3)
  function automatic void model(input bit bits[$], output bit es[$], output bit ep[$], output bit et[$]);
    bit hist[$];
    bit u, a, fb;
    int n;
    n = (bits.size() > MAX_LEN) ? MAX_LEN : bits.size();
    es = {};
    ep = {};
    et = {};
    for (int k = 0; k < n + TAIL_LEN; k++) begin
      fb = tap(hist, 2) ^ tap(hist, 3);
      u  = (k < n) ? bits[k] : fb;
      a  = u ^ fb;
      es.push_back(u);
      ep.push_back(a ^ tap(hist, 1) ^ tap(hist, 3));
      et.push_back(k >= n);
      hist.push_back(a);
    end
  endfunction

  function automatic logic [127:0] pack(input bit q[$], input int base, input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n && i < 128; i++)
      if (base + i < q.size()) v[i] = q[base + i];
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_en = 1'b0;
    din = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic send_bits(input bit bits[$]);
    foreach (bits[i]) begin
      din_en = 1'b1;
      din = bits[i];
      cyc();
    end
    din_en = 1'b0;
    din = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cap_len.size() >= target) ok = 1'b1;
    end
    cyc();
    repeat (3) cyc();
  endtask

  function automatic bit rbit();
    return 1'(($urandom >> 3) & 1);
  endfunction

  task automatic test_reset();
    bit q[$];
    bit ok;
    int lb;
    do_reset();
    n_checks++;
    if ({sys_out, par_out, out_en, tail_flag, frame_done, frame_len, len_err} !== 13'd0)
      $display("FAIL reset_state got=%b want=0", {sys_out, par_out, out_en, tail_flag, frame_done, frame_len, len_err});
    else n_pass++;
    q = {1'b1, 1'b1, 1'b0};
    lb = cap_len.size();
    send_bits(q);
    wait_done(lb + 1, ok);
    n_checks++;
    if (!ok || frame_len !== 7'd3) $display("FAIL reset_pre_len got=%0d want=3 ok=%0d", frame_len, ok);
    else n_pass++;
    rst = 1'b1;
    din_en = 1'b1;
    din = 1'b1;
    cyc();
    n_checks++;
    if ({sys_out, par_out, out_en, tail_flag, frame_done, frame_len, len_err} !== 13'd0)
      $display("FAIL reset_priority got=%b want=0", {sys_out, par_out, out_en, tail_flag, frame_done, frame_len, len_err});
    else n_pass++;
    rst = 1'b0;
    din_en = 1'b0;
    din = 1'b0;
    repeat (8) cyc();
  endtask

  task automatic test_zeros();
    bit q[$], es[$], ep[$], et[$];
    bit ok;
    int b, lb;
    do_reset();
    q = {};
    repeat (8) q.push_back(1'b0);
    model(q, es, ep, et);
    b = cap_sys.size();
    lb = cap_len.size();
    send_bits(q);
    wait_done(lb + 1, ok);
    n_checks++;
    if (cap_sys.size() - b != 8 + TAIL_LEN) $display("FAIL zeros_count got=%0d want=%0d", cap_sys.size() - b, 8 + TAIL_LEN);
    else n_pass++;
    n_checks++;
    if (pack(cap_sys, b, 11) !== 128'd0 || pack(cap_par, b, 11) !== 128'd0)
      $display("FAIL zeros_data sys=%h par=%h want=0", pack(cap_sys, b, 11), pack(cap_par, b, 11));
    else n_pass++;
    n_checks++;
    if (pack(cap_tail, b, 11) !== pack(et, 0, 11)) $display("FAIL zeros_tail got=%h want=%h", pack(cap_tail, b, 11), pack(et, 0, 11));
    else n_pass++;
    n_checks++;
    if (!ok || cap_len.size() != lb + 1 || frame_len !== 7'd8)
      $display("FAIL zeros_done pulses=%0d want=1 len=%0d want=8", cap_len.size() - lb, frame_len);
    else n_pass++;
  endtask

  task automatic test_impulse();
    bit q[$], xs[$], xp[$];
    bit ok;
    int b, lb;
    do_reset();
    q  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    xs = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    xp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    if (TAIL_LEN == 3) begin
      xs.push_back(1'b0); xs.push_back(1'b1); xs.push_back(1'b0);
      xp.push_back(1'b1); xp.push_back(1'b1); xp.push_back(1'b0);
    end
    b = cap_sys.size();
    lb = cap_len.size();
    send_bits(q);
    wait_done(lb + 1, ok);
    n_checks++;
    if (cap_sys.size() - b != xs.size() || pack(cap_sys, b, 9) !== pack(xs, 0, 9))
      $display("FAIL impulse_sys got=%h want=%h n=%0d", pack(cap_sys, b, 9), pack(xs, 0, 9), cap_sys.size() - b);
    else n_pass++;
    n_checks++;
    if (pack(cap_par, b, 9) !== pack(xp, 0, 9)) $display("FAIL impulse_par got=%h want=%h", pack(cap_par, b, 9), pack(xp, 0, 9));
    else n_pass++;
    n_checks++;
    if (!ok || frame_len !== 7'd6) $display("FAIL impulse_len got=%0d want=6", frame_len);
    else n_pass++;
  endtask

  task automatic test_random();
    bit q[$], es[$], ep[$], et[$];
    bit ok;
    int b, lb, n;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(20, 1);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(rbit());
      model(q, es, ep, et);
      b = cap_sys.size();
      lb = cap_len.size();
      send_bits(q);
      wait_done(lb + 1, ok);
      n_checks++;
      if (!ok || cap_sys.size() - b != es.size() || pack(cap_sys, b, 32) !== pack(es, 0, 32) ||
          pack(cap_par, b, 32) !== pack(ep, 0, 32) || pack(cap_tail, b, 32) !== pack(et, 0, 32))
        $display("FAIL random_frame%0d n=%0d par got=%h want=%h sys got=%h want=%h", f, n,
                 pack(cap_par, b, 32), pack(ep, 0, 32), pack(cap_sys, b, 32), pack(es, 0, 32));
      else n_pass++;
      n_checks++;
      if (frame_len !== 7'(n) || len_err !== 1'b0) $display("FAIL random_len%0d got=%0d want=%0d err=%0d", f, frame_len, n, len_err);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    bit q[$], es[$], ep[$], et[$];
    bit ok;
    int b, lb;
    do_reset();
    q = {};
    for (int i = 0; i < 70; i++) q.push_back(rbit());
    model(q, es, ep, et);
    b = cap_sys.size();
    lb = cap_len.size();
    send_bits(q);
    wait_done(lb + 1, ok);
    n_checks++;
    if (cap_sys.size() - b != MAX_LEN + TAIL_LEN || pack(cap_par, b, 70) !== pack(ep, 0, 70) || pack(cap_sys, b, 70) !== pack(es, 0, 70))
      $display("FAIL overflow_data n=%0d want=%0d par got=%h want=%h", cap_sys.size() - b, MAX_LEN + TAIL_LEN, pack(cap_par, b, 70), pack(ep, 0, 70));
    else n_pass++;
    n_checks++;
    if (!ok || len_err !== 1'b1 || frame_len !== 7'd64) $display("FAIL overflow_flags err=%0d want=1 len=%0d want=64", len_err, frame_len);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    bit q[$], es[$], ep[$], et[$];
    bit ok;
    int b, lb;
    do_reset();
    lb = cap_len.size();
    q = {1'b1, 1'b0, 1'b1};
    send_bits(q);
    rst = 1'b1;
    din_en = 1'b1;
    din = 1'b1;
    cyc();
    n_checks++;
    if ({sys_out, par_out, out_en, tail_flag, frame_done} !== 5'd0)
      $display("FAIL rstmid_outputs got=%b want=0", {sys_out, par_out, out_en, tail_flag, frame_done});
    else n_pass++;
    rst = 1'b0;
    din_en = 1'b0;
    din = 1'b0;
    repeat (8) cyc();
    n_checks++;
    if (cap_len.size() != lb) $display("FAIL rstmid_no_done got=%0d pulses want=0", cap_len.size() - lb);
    else n_pass++;
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(rbit());
    model(q, es, ep, et);
    b = cap_sys.size();
    send_bits(q);
    wait_done(lb + 1, ok);
    n_checks++;
    if (!ok || pack(cap_par, b, 8) !== pack(ep, 0, 8) || cap_sys.size() - b != es.size() || frame_len !== 7'd4)
      $display("FAIL rstmid_next par got=%h want=%h len=%0d want=4", pack(cap_par, b, 8), pack(ep, 0, 8), frame_len);
    else n_pass++;
  endtask

  task automatic test_ignored_din();
    bit q[$], es[$], ep[$], et[$];
    bit ok;
    int b, lb;
    do_reset();
    q = {};
    for (int i = 0; i < 5; i++) q.push_back(rbit());
    model(q, es, ep, et);
    b = cap_sys.size();
    lb = cap_len.size();
    send_bits(q);
    cyc();
    din_en = 1'b1;
    din = 1'b1;
    cyc();
    din_en = 1'b0;
    din = 1'b0;
    wait_done(lb + 1, ok);
    n_checks++;
    if (len_err !== 1'b1) $display("FAIL ignored_err got=%0d want=1", len_err);
    else n_pass++;
    n_checks++;
    if (!ok || cap_sys.size() - b != es.size() || pack(cap_par, b, 8) !== pack(ep, 0, 8) ||
        pack(cap_tail, b, 8) !== pack(et, 0, 8) || cap_len.size() != lb + 1 || frame_len !== 7'd5)
      $display("FAIL ignored_frame n=%0d want=%0d par got=%h want=%h pulses=%0d len=%0d", cap_sys.size() - b, es.size(),
               pack(cap_par, b, 8), pack(ep, 0, 8), cap_len.size() - lb, frame_len);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit qa[$], qb[$], es[$], ep[$], et[$], xs[$], xp[$];
    bit ok;
    int b, lb;
    do_reset();
    qa = {};
    qb = {};
    for (int i = 0; i < 4; i++) begin
      qa.push_back(rbit());
      qb.push_back(rbit());
    end
    model(qa, es, ep, et);
    xs = es;
    xp = ep;
    model(qb, es, ep, et);
    foreach (es[i]) begin
      xs.push_back(es[i]);
      xp.push_back(ep[i]);
    end
    b = cap_sys.size();
    lb = cap_len.size();
    send_bits(qa);
    repeat (MIN_GAP) cyc();
    send_bits(qb);
    wait_done(lb + 2, ok);
    n_checks++;
    if (!ok || cap_len.size() != lb + 2) $display("FAIL b2b_pulses got=%0d want=2", cap_len.size() - lb);
    else n_pass++;
    n_checks++;
    if (cap_len.size() < lb + 2 || cap_len[lb] !== 7'd4 || cap_len[lb + 1] !== 7'd4)
      $display("FAIL b2b_len got=%0d,%0d want=4,4", (cap_len.size() > lb) ? cap_len[lb] : 7'd0,
               (cap_len.size() > lb + 1) ? cap_len[lb + 1] : 7'd0);
    else n_pass++;
    n_checks++;
    if (cap_sys.size() - b != xs.size() || pack(cap_sys, b, 16) !== pack(xs, 0, 16) || pack(cap_par, b, 16) !== pack(xp, 0, 16) || len_err !== 1'b0)
      $display("FAIL b2b_data par got=%h want=%h sys got=%h want=%h err=%0d", pack(cap_par, b, 16), pack(xp, 0, 16),
               pack(cap_sys, b, 16), pack(xs, 0, 16), len_err);
    else n_pass++;
  endtask

  task automatic test_quiet_outputs();
    n_checks++;
    if (viol != 0) $display("FAIL quiet_outputs got=%0d violations want=0", viol);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_impulse();
    test_random();
    test_overflow();
    test_rst_mid();
    test_ignored_din();
    test_back_to_back();
    test_quiet_outputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
